// File: rtl/tanh_scheduler.sv
// tanh_scheduler: round-robin sharing of one tanh unit among N requesters,
// sequencing the unit's wa/en/comp handshake with a watchdog force-reset.
module tanh_scheduler #(
  parameter int N           = 4,
  parameter int W           = 32,
  parameter int TIMEOUT     = 64,
  parameter int RECOVER_CYC = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] x_in,
  output logic [N-1:0]   done,
  output logic [W-1:0]   y_out,
  output logic [N-1:0]   err,
  output logic           busy,
  output logic [W-1:0]   t_x,
  output logic           t_wa,
  output logic           t_comp,
  output logic           t_locked,
  input  logic           t_en,
  input  logic [W-1:0]   t_y
);
  localparam int SW  = (N > 2) ? $clog2(N) : 1;
  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam int RCW = $clog2(RECOVER_CYC + 1);

  typedef logic [SW:0]    ext_t;
  typedef logic [SW-1:0]  sel_t;
  typedef logic [WDW-1:0] wd_t;
  typedef logic [RCW-1:0] rc_t;

  localparam ext_t NV      = ext_t'(N);
  localparam wd_t  WD_MAX  = wd_t'(TIMEOUT);
  localparam rc_t  RC_LAST = rc_t'(RECOVER_CYC - 1);
  localparam rc_t  RC_END  = rc_t'(RECOVER_CYC);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_LAUNCH,
    S_WAIT,
    S_ACK,
    S_RECOVER
  } state_t;

  state_t         state_q;
  sel_t           ptr_q;
  sel_t           sel_q;
  logic [W-1:0]   t_x_q;
  logic [W-1:0]   y_q;
  logic [N-1:0]   done_q;
  logic [N-1:0]   err_q;
  logic           busy_q;
  logic           wa_q;
  logic           comp_q;
  logic           lock_q;
  logic [1:0]     en_cnt_q;
  logic [1:0]     en_cnt_d;
  wd_t            wd_q;
  wd_t            wd_d;
  rc_t            rc_q;

  logic [2*N-1:0] req2;
  logic [N-1:0]   rot;
  logic [N-1:0]   sel_oh;
  ext_t           off;
  ext_t           sum;
  ext_t           sum2;
  logic           found;
  sel_t           pick;
  sel_t           pick_nx;
  logic [W-1:0]   xs [N];

  for (genvar g = 0; g < N; g++) begin : g_x
    assign xs[g] = x_in[g*W +: W];
  end

  // Rotate so the pointer lane sits at bit 0; lowest set bit wins.
  assign req2   = {req, req};
  assign rot    = N'(req2 >> ptr_q);
  assign sel_oh = N'(1) << sel_q;

  always_comb begin
    found = 1'b0;
    off   = '0;
    for (int i = N-1; i >= 0; i--) begin
      if (rot[i]) begin
        found = 1'b1;
        off   = ext_t'(i);
      end
    end
    sum = ext_t'(ptr_q) + off;
    if (sum >= NV) sum = sum - NV;
    pick    = sel_t'(sum);
    sum2    = ext_t'(pick) + ext_t'(1);
    pick_nx = (sum2 == NV) ? '0 : sel_t'(sum2);
  end

  // The unit raises en a cycle before a negative result is final.
  always_comb begin
    en_cnt_d = 2'd0;
    if (t_en) en_cnt_d = (en_cnt_q == 2'd2) ? 2'd2 : en_cnt_q + 2'd1;
    wd_d = wd_q + wd_t'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      sel_q    <= '0;
      t_x_q    <= '0;
      y_q      <= '0;
      done_q   <= '0;
      err_q    <= '0;
      busy_q   <= 1'b0;
      wa_q     <= 1'b1;
      comp_q   <= 1'b0;
      lock_q   <= 1'b1;
      en_cnt_q <= '0;
      wd_q     <= '0;
      rc_q     <= '0;
    end else begin
      done_q <= '0;
      err_q  <= '0;
      wa_q   <= 1'b1;
      comp_q <= 1'b0;
      lock_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (|req) begin
            state_q <= S_GRANT;
            busy_q  <= 1'b1;
          end
        end
        S_GRANT: begin
          if (found) begin
            sel_q   <= pick;
            t_x_q   <= xs[pick];
            ptr_q   <= pick_nx;
            wa_q    <= 1'b0;
            state_q <= S_LAUNCH;
          end else begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_LAUNCH: begin
          wd_q     <= '0;
          en_cnt_q <= '0;
          state_q  <= S_WAIT;
        end
        S_WAIT: begin
          en_cnt_q <= en_cnt_d;
          wd_q     <= wd_d;
          if (en_cnt_d == 2'd2) begin
            y_q     <= t_y;
            done_q  <= sel_oh;
            comp_q  <= 1'b1;
            state_q <= S_ACK;
          end else if (wd_d == WD_MAX) begin
            lock_q  <= 1'b1;
            rc_q    <= '0;
            state_q <= S_RECOVER;
          end
        end
        S_ACK: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        S_RECOVER: begin
          rc_q <= rc_q + rc_t'(1);
          if (rc_q == RC_END) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else if (rc_q == RC_LAST) begin
            err_q <= sel_oh;
          end else begin
            lock_q <= 1'b1;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign done     = done_q;
  assign y_out    = y_q;
  assign err      = err_q;
  assign busy     = busy_q;
  assign t_x      = t_x_q;
  assign t_wa     = wa_q;
  assign t_comp   = comp_q;
  assign t_locked = lock_q;
endmodule

// File: tb/tb_tanh_scheduler.sv
// tb_tanh_scheduler: behavioural tanh unit stub, vector table and
// scoreboard checking done/err order, results and handshake timing.
module tb_tanh_scheduler;
  localparam int N   = 4;
  localparam int W   = 32;
  localparam int TMO = 64;
  localparam int RCY = 2;

  logic           clk   = 1'b0;
  logic           rst   = 1'b1;
  logic [N-1:0]   req   = '0;
  logic [N*W-1:0] x_in  = '0;
  logic [N-1:0]   done;
  logic [N-1:0]   err;
  logic [W-1:0]   y_out;
  logic [W-1:0]   t_x;
  logic           busy;
  logic           t_wa;
  logic           t_comp;
  logic           t_locked;
  logic           t_en  = 1'b0;
  logic [W-1:0]   t_y   = '0;

  tanh_scheduler #(
    .N(N), .W(W), .TIMEOUT(TMO), .RECOVER_CYC(RCY)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .x_in(x_in),
    .done(done), .y_out(y_out), .err(err), .busy(busy),
    .t_x(t_x), .t_wa(t_wa), .t_comp(t_comp),
    .t_locked(t_locked), .t_en(t_en), .t_y(t_y)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           lane;
    logic [W-1:0] y;
    logic         is_err;
    int           maxlat;
  } exp_t;

  typedef struct {
    int           lane;
    logic [W-1:0] x;
    logic [W-1:0] y;
    int           maxlat;
    logic         drop;
  } vec_t;

  exp_t         sbq[$];
  exp_t         e;
  int           checks     = 0;
  int           errors     = 0;
  int           cyc        = 0;
  int           launch_cyc = 0;
  int           lock_cnt   = 0;
  int           ndone      = 0;
  logic [W-1:0] last_y     = '0;

  task automatic chk(input string nm, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [W-1:0] mag_of(input logic [W-1:0] x);
    return x[W-1] ? -x : x;
  endfunction

  function automatic logic [W-1:0] unit_mag(input logic [W-1:0] m);
    if (m > 32'h0533_3333) return 32'h0400_0000;
    if (m == 32'h0400_0000) return 32'h030B_DF56;
    return m - (m >> 3);
  endfunction

  // Unit stub: positive magnitude on the first en cycle, sign fixed next.
  int           ust       = 0;
  int           ucnt      = 0;
  logic         stub_dead = 1'b0;
  logic [W-1:0] ux        = '0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (t_locked === 1'b1) begin
      ust  <= 0;
      t_en <= 1'b0;
      t_y  <= '0;
    end else begin
      case (ust)
        0: if (t_wa === 1'b0) begin
          ux   <= t_x;
          ucnt <= (mag_of(t_x) > 32'h0533_3333) ? 1 : 9;
          ust  <= 1;
        end
        1: if (!stub_dead) begin
          if (ucnt == 0) begin
            t_en <= 1'b1;
            t_y  <= unit_mag(mag_of(ux));
            ust  <= 2;
          end else begin
            ucnt <= ucnt - 1;
          end
        end
        2: begin
          t_y <= ux[W-1] ? -unit_mag(mag_of(ux)) : unit_mag(mag_of(ux));
          ust <= 3;
        end
        default: if (t_comp === 1'b1) begin
          t_en <= 1'b0;
          ust  <= 0;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (t_wa === 1'b0) launch_cyc = cyc;
      if (t_locked === 1'b1) lock_cnt++;
      if ((done | err) != '0) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: done=%b err=%b none pending",
                   done, err);
        end else begin
          e = sbq.pop_front();
          ndone++;
          if (e.is_err) begin
            chk("err_vec", W'(err), W'(1 << e.lane));
            chk("err_no_done", W'(done), '0);
            chk("err_y_hold", y_out, last_y);
            chk("err_time", W'(cyc - launch_cyc), W'(TMO + RCY + 1));
          end else begin
            chk("done_vec", W'(done), W'(1 << e.lane));
            chk("done_no_err", W'(err), '0);
            chk("y_out", y_out, e.y);
            chk("comp_hi", W'(t_comp), 1);
            chk("wa_hi_in_ack", W'(t_wa), 1);
            if (e.maxlat > 0)
              chk("short_latency", W'(cyc - launch_cyc <= e.maxlat), 1);
            last_y = e.y;
          end
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_launch(input string nm);
    int n;
    n = 0;
    while (t_wa !== 1'b0 && n < 40) begin
      step();
      n++;
    end
    chk(nm, W'(t_wa), '0);
  endtask

  task automatic wait_done(input int target, input int budget,
                           input string nm);
    int n;
    n = 0;
    while (ndone < target && n < budget) begin
      step();
      n++;
    end
    chk(nm, W'(ndone >= target), 1);
    if (ndone < target) sbq.delete();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_done"}, W'(done), '0);
    chk({tag, "_err"}, W'(err), '0);
    chk({tag, "_busy"}, W'(busy), '0);
    chk({tag, "_y"}, y_out, '0);
    chk({tag, "_tx"}, t_x, '0);
    chk({tag, "_wa"}, W'(t_wa), 1);
    chk({tag, "_comp"}, W'(t_comp), '0);
    chk({tag, "_locked"}, W'(t_locked), 1);
  endtask

  vec_t vecs[6];

  initial begin
    int n0;
    vec_t v;
    vecs[0] = '{0, 32'h0400_0000, 32'h030B_DF56, 0, 1'b0};
    vecs[1] = '{2, 32'hFC00_0000, 32'hFCF4_20AA, 0, 1'b0};
    vecs[2] = '{1, 32'h0600_0000, 32'h0400_0000, 8, 1'b0};
    vecs[3] = '{3, 32'hFA00_0000, 32'hFC00_0000, 8, 1'b1};
    vecs[4] = '{0, 32'h0080_0000, 32'h0070_0000, 0, 1'b0};
    vecs[5] = '{2, 32'hFF80_0000, 32'hFF90_0000, 0, 1'b0};

    repeat (2) step();
    chk_reset_vals("rst");
    rst = 1'b0;
    step();
    chk("locked_release", W'(t_locked), '0);

    for (int i = 0; i < 6; i++) begin
      v = vecs[i];
      x_in[v.lane*W +: W] = v.x;
      sbq.push_back('{v.lane, v.y, 1'b0, v.maxlat});
      n0 = ndone;
      req[v.lane] = 1'b1;
      wait_launch("launch");
      x_in[v.lane*W +: W] = ~v.x;
      if (v.drop) req[v.lane] = 1'b0;
      step();
      chk("t_x_hold", t_x, v.x);
      wait_done(n0 + 1, 40, "done_seen");
      req[v.lane] = 1'b0;
      step();
      chk("busy_after", W'(busy), '0);
      chk("comp_after", W'(t_comp), '0);
    end

    x_in[2*W +: W] = 32'h0200_0000;
    sbq.push_back('{2, 32'h01C0_0000, 1'b0, 0});
    req = 4'b0100;
    wait_launch("mid_launch");
    repeat (3) step();
    rst = 1'b1;
    sbq.delete();
    step();
    chk_reset_vals("midrst");
    req = '0;
    rst = 1'b0;
    repeat (15) step();
    chk("midrst_idle", W'(busy), '0);

    for (int i = 0; i < N; i++)
      x_in[i*W +: W] = 32'h0010_0000 * (i + 1);
    sbq.push_back('{0, 32'h000E_0000, 1'b0, 0});
    sbq.push_back('{1, 32'h001C_0000, 1'b0, 0});
    sbq.push_back('{2, 32'h002A_0000, 1'b0, 0});
    sbq.push_back('{3, 32'h0038_0000, 1'b0, 0});
    sbq.push_back('{0, 32'h000E_0000, 1'b0, 0});
    n0 = ndone;
    req = 4'b1111;
    wait_done(n0 + 5, 200, "rr_done");
    req = '0;
    repeat (3) step();

    stub_dead = 1'b1;
    x_in[3*W +: W] = 32'h0100_0000;
    sbq.push_back('{3, '0, 1'b1, 0});
    n0 = ndone;
    req = 4'b1000;
    wait_launch("wd_launch");
    lock_cnt = 0;
    wait_done(n0 + 1, 100, "wd_err_seen");
    req = '0;
    chk("wd_lock_cycles", W'(lock_cnt), W'(RCY));
    stub_dead = 1'b0;
    step();
    chk("wd_busy_after", W'(busy), '0);

    x_in[0 +: W] = 32'h0040_0000;
    sbq.push_back('{0, 32'h0038_0000, 1'b0, 0});
    n0 = ndone;
    req = 4'b0001;
    wait_done(n0 + 1, 40, "post_wd_done");
    req = '0;
    repeat (4) step();
    chk("sb_empty", W'(sbq.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/tanh_scheduler.md
# tanh_scheduler

Round-robin scheduler that shares one tanh evaluation unit among N requesters (e.g. LSTM gate lanes). It captures the winning requester's Q5.26 operand and sequences the unit's start/hold (`wa`), completion (`en`) and acknowledge (`comp`) handshake. It returns the result to the requester with a one-cycle done pulse. It also runs a watchdog that force-resets the unit through its `locked` input if completion never arrives.

## Interface
- `N`, 4: number of requesters (2..8).
- `W`, 32: operand/result width; signed Q5.26 (1 sign, 5 integer, 26 fraction bits).
- `TIMEOUT`, 64: maximum cycles from launch to unit completion before recovery.
- `RECOVER_CYC`, 2: cycles `t_locked` is held high during recovery.

- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req` in N: level request per requester; held until its `done`.
- `x_in` in N*W: operand of requester i at bits [i*W +: W].
- `done` out N: one-cycle pulse to the requester whose result is on `y_out`.
- `y_out` out W: result, valid only in the `done` cycle, held otherwise.
- `err` out N: one-cycle pulse instead of `done` when the watchdog fired.
- `busy` out 1: high whenever the FSM is not IDLE.
- `t_x` out W: operand to the unit (its `ox`).
- `t_wa` out 1: unit hold; 1 keeps the unit idle, 0 starts it.
- `t_comp` out 1: unit acknowledge.
- `t_locked` out 1: unit force-reset.
- `t_en` in 1: unit result-valid.
- `t_y` in W: unit result.

## Operation
- Reset values: `done`=0, `err`=0, `busy`=0, `y_out`=0, `t_x`=0, `t_wa`=1, `t_comp`=0, `t_locked`=1 for the first cycle after reset, round-robin pointer=0, FSM=IDLE.
- The FSM has six states.
  - **IDLE**: if any `req` bit is set, go to GRANT.
  - **GRANT**: pick the first set `req` bit at or after the pointer, wrapping modulo N. Latch its index into `sel` and its operand into `t_x`. Set the pointer to `sel+1` mod N. Go to LAUNCH.
  - **LAUNCH**: drive `t_wa`=0 for exactly one cycle. Clear the watchdog counter. Go to WAIT.
  - **WAIT**: `t_wa`=1. Count `t_en` consecutive-high cycles (`en_cnt`, saturating at 2) and increment the watchdog.
    - When `en_cnt` reaches 2, capture `t_y` into `y_out` and go to ACK. Two consecutive cycles are required because the unit raises `en` one cycle before its sign correction lands on negative inputs.
    - When the watchdog reaches TIMEOUT, go to RECOVER.
  - **ACK**: `t_comp`=1 for one cycle and `done[sel]`=1. Go to IDLE.
  - **RECOVER**: `t_locked`=1 for RECOVER_CYC cycles, then `err[sel]`=1 for one cycle and go to IDLE.
- `t_x` holds the latched operand from GRANT through ACK/RECOVER. The unit samples it one cycle after LAUNCH, and a changing `x_in` must not corrupt an operation in flight.
- If the granted requester drops `req` mid-operation, the operation still completes and the `done`/`err` pulse is still issued. The requester ignores it.
- Requests arriving during an operation wait; fairness is strict round-robin with no starvation.
- Arithmetic: no computation; values pass bit-exact. `y_out` is never modified between `done` pulses.
- `rst` in any state returns every output to its reset value on the next edge and abandons the operation without a `done` pulse. `t_locked` pulses high so the unit restarts cleanly.

## Timing
- Request to operand presented: `req` seen in IDLE at cycle 0, GRANT at 1, LAUNCH at 2, unit loads `t_x` at 3.
- Total latency from `req` to `done` is 4 + unit latency + 2.
- Nominal unit is about 10 cycles for |x| ≤ 1.3 and about 2 cycles for the saturated path.
- Back-to-back: the next GRANT occurs in the cycle after ACK's IDLE, giving at least 2 idle cycles between unit operations. This lets the unit return to its idle state with `en`=0 before relaunch.
- `t_wa` is low only in LAUNCH. `t_comp` is high only in ACK. The two are never high in the same cycle.
- Watchdog: `err` fires at TIMEOUT + RECOVER_CYC + 1 cycles after LAUNCH.

## Test plan
- **Single request**: `req`=0001, `x_in[0]`=0x0400_0000 (+1.0). Expect exactly one `done[0]`, `y_out` equal to the unit's tanh(1.0) ≈ 0x030B_xxxx, `t_comp` high one cycle, `busy` low afterwards.
- **Negative operand**: `x_in[2]`=0xFC00_0000 (−1.0). Expect `y_out` to be the two's complement of the +1.0 result. This checks the double-`en` capture; a capture on the first `en` cycle must fail.
- **Round-robin**: hold `req`=1111 continuously. Expect `done` order 0,1,2,3,0. Each `y_out` matches its lane's operand; no lane is granted twice in a row.
- **Saturation**: `x_in[1]`=0x0600_0000 (+1.5). Expect `y_out`=0x0400_0000 (1.0) via the short path and `done[1]` within 8 cycles of LAUNCH.
- **Watchdog**: stub the unit so `t_en` stays 0. Expect `t_locked` high for 2 cycles after 64 WAIT cycles, then `err[sel]`, no `done`, and the next request served normally.
- **Reset mid-operation**: assert `rst` during WAIT. Expect outputs at reset values next cycle, `t_locked`=1, no `done`, pointer back to 0.
